// File: rtl/stereo_ycrcb_arbiter.sv
// stereo_ycrcb_arbiter: round-robin sharing of one rgb_to_ycrcb converter between two
// buffered RGB565 streams, with valid/select/coordinate tags delayed to match the converter.
module stereo_ycrcb_arbiter #(
  parameter int LATENCY = 3,
  parameter int HW = 11,
  parameter int VW = 10
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          a_valid_in,
  input  logic [15:0]   a_pixel_in,
  input  logic [HW-1:0] a_hcount_in,
  input  logic [VW-1:0] a_vcount_in,
  output logic          a_ready_out,
  input  logic          b_valid_in,
  input  logic [15:0]   b_pixel_in,
  input  logic [HW-1:0] b_hcount_in,
  input  logic [VW-1:0] b_vcount_in,
  output logic          b_ready_out,
  output logic [9:0]    conv_r_out,
  output logic [9:0]    conv_g_out,
  output logic [9:0]    conv_b_out,
  input  logic [9:0]    conv_y_in,
  input  logic [9:0]    conv_cr_in,
  input  logic [9:0]    conv_cb_in,
  output logic          out_valid,
  output logic          out_sel,
  output logic [9:0]    out_y,
  output logic [9:0]    out_cr,
  output logic [9:0]    out_cb,
  output logic [HW-1:0] out_hcount,
  output logic [VW-1:0] out_vcount
);
  localparam int TW = 2 + HW + VW;
  logic          a_full_q, a_full_d, b_full_q, b_full_d;
  logic [15:0]   a_pix_q, a_pix_d, b_pix_q, b_pix_d;
  logic [HW-1:0] a_h_q, a_h_d, b_h_q, b_h_d;
  logic [VW-1:0] a_v_q, a_v_d, b_v_q, b_v_d;
  logic          last_q, last_d;
  logic [9:0]    r_q, r_d, g_q, g_d, bl_q, bl_d;
  logic [TW-1:0] tag_q [LATENCY+1];
  logic [TW-1:0] tag_d [LATENCY+1];
  logic          gnt_a, gnt_b, gnt, sel;
  logic [15:0]   pix;
  always_comb begin
    gnt_a = a_full_q && (!b_full_q || last_q);
    gnt_b = b_full_q && (!a_full_q || !last_q);
    gnt = gnt_a || gnt_b;
    sel = gnt_b;
    pix = sel ? b_pix_q : a_pix_q;
    // a granted buffer cannot refill on the same edge it drains
    a_full_d = a_full_q ? !gnt_a : a_valid_in;
    b_full_d = b_full_q ? !gnt_b : b_valid_in;
    a_pix_d = (!a_full_q && a_valid_in) ? a_pixel_in : a_pix_q;
    a_h_d = (!a_full_q && a_valid_in) ? a_hcount_in : a_h_q;
    a_v_d = (!a_full_q && a_valid_in) ? a_vcount_in : a_v_q;
    b_pix_d = (!b_full_q && b_valid_in) ? b_pixel_in : b_pix_q;
    b_h_d = (!b_full_q && b_valid_in) ? b_hcount_in : b_h_q;
    b_v_d = (!b_full_q && b_valid_in) ? b_vcount_in : b_v_q;
    last_d = gnt ? sel : last_q;
    r_d = gnt ? {pix[15:11], pix[15:11]} : r_q;
    g_d = gnt ? {pix[10:5], pix[10:7]} : g_q;
    bl_d = gnt ? {pix[4:0], pix[4:0]} : bl_q;
    tag_d[0] = gnt ? {1'b1, sel, sel ? b_h_q : a_h_q, sel ? b_v_q : a_v_q} : '0;
    for (int i = 1; i <= LATENCY; i++) tag_d[i] = tag_q[i-1];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_pix_q <= '0;
      a_h_q <= '0;
      a_v_q <= '0;
      b_pix_q <= '0;
      b_h_q <= '0;
      b_v_q <= '0;
      last_q <= 1'b1;
      r_q <= '0;
      g_q <= '0;
      bl_q <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_pix_q <= a_pix_d;
      a_h_q <= a_h_d;
      a_v_q <= a_v_d;
      b_pix_q <= b_pix_d;
      b_h_q <= b_h_d;
      b_v_q <= b_v_d;
      last_q <= last_d;
      r_q <= r_d;
      g_q <= g_d;
      bl_q <= bl_d;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= tag_d[i];
    end
  end
  assign a_ready_out = !a_full_q;
  assign b_ready_out = !b_full_q;
  assign conv_r_out = r_q;
  assign conv_g_out = g_q;
  assign conv_b_out = bl_q;
  assign out_valid = tag_q[LATENCY][TW-1];
  assign out_sel = tag_q[LATENCY][TW-2];
  assign out_hcount = tag_q[LATENCY][VW +: HW];
  assign out_vcount = tag_q[LATENCY][VW-1:0];
  assign out_y = conv_y_in;
  assign out_cr = conv_cr_in;
  assign out_cb = conv_cb_in;
endmodule
